// File: rtl/lsu_dm_port.sv
// lsu_dm_port: load/store unit front end for a data memory with one-cycle
// read latency. Accepts one request at a time, drives the memory port, and
// returns sign/zero-extended load data with a single-cycle response pulse.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op                      000 lb 001 lbu 010 lh 011 lhu 100 lw
//                               101 sb 110 sh 111 sw
//   req_addr/req_wdata/req_pc   byte address, store source, instruction PC
//   resp_valid                  one-cycle completion pulse
//   resp_rdata/resp_exc         extended load data / misalignment flag
//   dm_PC/dm_wen/dm_BE/dm_wdata/dm_ren/dm_addr   memory port outputs
//   dm_rdata                    memory read data, one cycle after dm_ren
module lsu_dm_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [31:0] dm_PC,
    output logic        dm_wen,
    output logic [3:0]  dm_BE,
    output logic [31:0] dm_wdata,
    output logic        dm_ren,
    output logic [31:0] dm_addr,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;
    logic        accept, misal, store_q;
    logic [3:0]  be_nxt;
    logic [31:0] wd_nxt, load_fmt;
    logic [7:0]  lb_byte;
    logic [15:0] lh_half;

    assign accept  = req_valid & req_ready & ~reset;
    // Stores are 101/110/111; 100 is lw.
    assign store_q = op_q[2] & (|op_q[1:0]);

    // Alignment check on the incoming request.
    always_comb begin
        misal = 1'b0;
        case (req_op)
            3'b010, 3'b011, 3'b110: misal = req_addr[0];
            3'b100, 3'b111:         misal = |req_addr[1:0];
            default:                misal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_nxt = 4'b0000;
        wd_nxt = 32'h0;
        case (req_op)
            3'b101: begin
                be_nxt = 4'b0001 << req_addr[1:0];
                wd_nxt = {4{req_wdata[7:0]}};
            end
            3'b110: begin
                be_nxt = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_nxt = {2{req_wdata[15:0]}};
            end
            3'b111: begin
                be_nxt = 4'b1111;
                wd_nxt = req_wdata;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension using the captured offset.
    always_comb begin
        lb_byte = dm_rdata[7:0];
        case (lo_q)
            2'd0: lb_byte = dm_rdata[7:0];
            2'd1: lb_byte = dm_rdata[15:8];
            2'd2: lb_byte = dm_rdata[23:16];
            2'd3: lb_byte = dm_rdata[31:24];
            default: ;
        endcase
        lh_half  = lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_fmt = dm_rdata;
        case (op_q)
            3'b000: load_fmt = {{24{lb_byte[7]}}, lb_byte};
            3'b001: load_fmt = {24'h0, lb_byte};
            3'b010: load_fmt = {{16{lh_half[15]}}, lh_half};
            3'b011: load_fmt = {16'h0, lh_half};
            default: load_fmt = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Strobes and handshake are decoded from state, so a reset edge clears
    // them immediately and abandons any access in flight.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        dm_wen     = 1'b0;
        dm_ren     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = misal ? RESP : ISSUE;
            end
            ISSUE: begin
                dm_wen    = store_q;
                dm_ren    = ~store_q;
                state_nxt = store_q ? RESP : WAIT;
            end
            WAIT: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 3'b000;
            lo_q       <= 2'b00;
            dm_addr    <= 32'h0;
            dm_PC      <= 32'h0;
            dm_BE      <= 4'h0;
            dm_wdata   <= 32'h0;
            resp_rdata <= 32'h0;
            resp_exc   <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                lo_q     <= req_addr[1:0];
                dm_addr  <= {req_addr[31:2], 2'b00};
                dm_PC    <= req_pc;
                dm_BE    <= be_nxt;
                dm_wdata <= wd_nxt;
                if (misal) begin
                    resp_rdata <= 32'h0;
                    resp_exc   <= 1'b1;
                end
            end
            if (state == ISSUE && store_q) begin
                resp_rdata <= 32'h0;
                resp_exc   <= 1'b0;
            end
            if (state == WAIT) begin
                resp_rdata <= load_fmt;
                resp_exc   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dm_port.sv
module tb_lsu_dm_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_pc = 32'h0;
    logic        resp_valid, resp_exc, dm_wen, dm_ren;
    logic [31:0] resp_rdata, dm_PC, dm_wdata, dm_addr;
    logic [3:0]  dm_BE;
    logic [31:0] dm_rdata = 32'h0;

    lsu_dm_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .dm_PC(dm_PC), .dm_wen(dm_wen), .dm_BE(dm_BE), .dm_wdata(dm_wdata),
        .dm_ren(dm_ren), .dm_addr(dm_addr), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Data memory: 64 words, one-cycle registered read, byte-enabled write.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (dm_ren) dm_rdata <= mem[dm_addr[7:2]];
        if (dm_wen)
            for (int b = 0; b < 4; b++)
                if (dm_BE[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [3:0]  be;
        int          cyc;
    } wr_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          cyc;
    } rd_t;
    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          cyc;
    } rs_t;

    wr_t wq[$];
    rd_t rq[$];
    rs_t sq[$];

    // Monitor: compares every memory strobe and response against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (dm_wen) begin
                chk("wen_ren_excl", {31'h0, dm_ren}, 32'h0);
                if (wq.size() == 0) chk("unexp_wen", {31'h0, dm_wen}, 32'h0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", dm_addr, w.addr);
                    chk("wr_be", {28'h0, dm_BE}, {28'h0, w.be});
                    chk("wr_wdata", dm_wdata, w.wdata);
                    chk("wr_pc", dm_PC, w.pc);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (dm_ren) begin
                if (rq.size() == 0) chk("unexp_ren", {31'h0, dm_ren}, 32'h0);
                else begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_addr", dm_addr, r.addr);
                    chk("rd_be", {28'h0, dm_BE}, 32'h0);
                    chk("rd_pc", dm_PC, r.pc);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end
            if (resp_valid) begin
                if (sq.size() == 0) chk("unexp_resp", {31'h0, resp_valid}, 32'h0);
                else begin
                    rs_t s;
                    s = sq.pop_front();
                    chk("resp_rdata", resp_rdata, s.rdata);
                    chk("resp_exc", {31'h0, resp_exc}, {31'h0, s.exc});
                    chk("resp_cycle", cyc, s.cyc);
                end
            end
        end
    end

    int last_acc = 0;

    // Present a request (called at a negedge) and wait for acceptance; push
    // hand-computed expectations. Returns at the negedge after the accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                         input bit exp_exc, input bit exp_resp);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = pc;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        last_acc = cyc;
        if (exp_exc) begin
            if (exp_resp) sq.push_back('{32'h0, 1'b1, cyc + 1});
        end else if (op[2] && op[1:0] != 2'b00) begin
            wq.push_back('{{a[31:2], 2'b00}, exp_wd, pc, exp_be, cyc + 1});
            if (exp_resp) sq.push_back('{32'h0, 1'b0, cyc + 2});
        end else begin
            rq.push_back('{{a[31:2], 2'b00}, pc, cyc + 1});
            if (exp_resp) sq.push_back('{exp_rd, 1'b0, cyc + 3});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((sq.size() != 0 || wq.size() != 0 || rq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_resp", sq.size(), 0);
        chk("drain_mem", wq.size() + rq.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int a0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_strobes", {29'h0, dm_wen, dm_ren, resp_valid}, 32'h0);
        chk("rst_addr", dm_addr, 32'h0);
        chk("rst_be_exc", {27'h0, dm_BE, resp_exc}, 32'h0);
        chk("rst_wdata_pc", dm_wdata | dm_PC | resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // sw then lw
        issue(3'b111, 32'h10, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 1);
        drain();
        issue(3'b100, 32'h10, 32'h0, 32'h104, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 1);
        drain();

        // sb then lw over a zeroed word
        issue(3'b101, 32'h22, 32'h000000A5, 32'h108, 4'b0100, 32'hA5A5A5A5, 32'h0, 0, 1);
        drain();
        issue(3'b100, 32'h20, 32'h0, 32'h10C, 4'b0000, 32'h0, 32'h00A50000, 0, 1);
        drain();

        // sh upper half lane
        issue(3'b110, 32'h2E, 32'h0000BEEF, 32'h110, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 1);
        drain();

        // Byte and half extension
        issue(3'b111, 32'h40, 32'h80FF7F01, 32'h120, 4'b1111, 32'h80FF7F01, 32'h0, 0, 1);
        drain();
        issue(3'b000, 32'h43, 32'h0, 32'h124, 4'b0, 32'h0, 32'hFFFFFF80, 0, 1);
        drain();
        issue(3'b001, 32'h43, 32'h0, 32'h128, 4'b0, 32'h0, 32'h00000080, 0, 1);
        drain();
        issue(3'b010, 32'h42, 32'h0, 32'h12C, 4'b0, 32'h0, 32'hFFFF80FF, 0, 1);
        drain();
        issue(3'b011, 32'h40, 32'h0, 32'h130, 4'b0, 32'h0, 32'h00007F01, 0, 1);
        drain();
        issue(3'b000, 32'h41, 32'h0, 32'h134, 4'b0, 32'h0, 32'h0000007F, 0, 1);
        drain();

        // Misaligned accesses: exception at accept+1, no strobes
        issue(3'b100, 32'h6, 32'h0, 32'h140, 4'b0, 32'h0, 32'h0, 1, 1);
        drain();
        issue(3'b110, 32'h5, 32'h1234, 32'h144, 4'b0, 32'h0, 32'h0, 1, 1);
        drain();

        // Request gating: req_valid held high across alternating sw/lw
        issue(3'b111, 32'h30, 32'h11223344, 32'h200, 4'b1111, 32'h11223344, 32'h0, 0, 1);
        a0 = last_acc;
        issue(3'b100, 32'h30, 32'h0, 32'h204, 4'b0, 32'h0, 32'h11223344, 0, 1);
        chk("gap_sw_lw", last_acc - a0, 3);
        a0 = last_acc;
        issue(3'b111, 32'h34, 32'h55667788, 32'h208, 4'b1111, 32'h55667788, 32'h0, 0, 1);
        chk("gap_lw_sw", last_acc - a0, 4);
        a0 = last_acc;
        issue(3'b100, 32'h34, 32'h0, 32'h20C, 4'b0, 32'h0, 32'h55667788, 0, 1);
        chk("gap_sw_lw2", last_acc - a0, 3);
        drain();

        // Reset mid-load: lw accepted, reset asserted during WAIT
        issue(3'b100, 32'h40, 32'h0, 32'h300, 4'b0, 32'h0, 32'h0, 0, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_strobes", {29'h0, dm_wen, dm_ren, resp_valid}, 32'h0);
        chk("mid_rst_dm", dm_addr | dm_wdata | dm_PC | {28'h0, dm_BE}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        issue(3'b011, 32'h42, 32'h0, 32'h304, 4'b0, 32'h0, 32'h000080FF, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_dm_port.md
# lsu_dm_port

Load/store unit that initiates data-memory accesses for the CPU pipeline. It accepts one load or store request at a time and drives the data-memory port: PC, write enable, byte enables, write data, read enable and address. It returns formatted load data, sign- or zero-extended, through a single-cycle response pulse. It sits between the execute/memory stage and the data memory, which has one-cycle read latency.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_op` in 3: operation code.
  - 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw.
  - 101 sb, 110 sh, 111 sw.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store source; the low byte/half/word is used.
- `req_pc` in 32: PC of the instruction, for the memory debug trace.
- `resp_valid` out 1: one-cycle completion pulse. There is no back-pressure.
- `resp_rdata` out 32: extended load result; 0 for stores and exceptions.
- `resp_exc` out 1: misaligned-address exception, valid with `resp_valid`.
- `dm_PC` out 32: PC driven to memory.
- `dm_wen` out 1: memory write strobe.
- `dm_BE` out 4: byte enables.
- `dm_wdata` out 32: replicated store data.
- `dm_ren` out 1: memory read strobe.
- `dm_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dm_rdata` in 32: memory read data, registered in memory one cycle after `dm_ren`.

## Operation
**States**
- IDLE: `req_ready`=1.
- ISSUE: exactly one of `dm_wen`/`dm_ren` is 1.
- WAIT: loads only; capture and format `dm_rdata`.
- RESP: `resp_valid`=1.

**Transitions**
- IDLE → ISSUE on accept of an aligned request.
- IDLE → RESP on accept of a misaligned request, with `resp_exc`=1.
- ISSUE → WAIT for a load; ISSUE → RESP for a store.
- WAIT → RESP.
- RESP → IDLE.

**Captured fields.** On accept, register op, `addr[1:0]`, the aligned address, the PC and the store data. Requests are ignored outside IDLE and while `reset` is high.

**Misalignment**
- lh/lhu/sh with `addr[0]`≠0.
- lw/sw with `addr[1:0]`≠0.
- The memory strobes are never asserted for a misaligned request.

**Byte enables**
- sb: `4'b0001 << addr[1:0]`.
- sh: `addr[1] ? 4'b1100 : 4'b0011`.
- sw: `4'b1111`.
- Loads: `4'b0000`.

**Write data**
- sb: `{4{wdata[7:0]}}`.
- sh: `{2{wdata[15:0]}}`.
- sw: `wdata`.

**Load extraction**
- Source lane: byte at `dm_rdata[8*a+7:8*a]` with `a=addr[1:0]`; half at `dm_rdata[16*addr[1]+15:16*addr[1]]`.
- lb/lh: sign-extend to 32 bits.
- lbu/lhu: zero-extend to 32 bits.
- lw: pass the full word.

**Output holding**
- `dm_addr`, `dm_BE`, `dm_wdata` and `dm_PC` are registers. They hold their values from ISSUE until the next accept.
- The strobes are 0 in every state except ISSUE.
- `resp_rdata` and `resp_exc` hold their values until the next RESP, but are only meaningful while `resp_valid`=1.

## Timing
**Store.** Accept at cycle T.
- T+1: ISSUE; memory writes at the end of T+1.
- T+2: `resp_valid`.
- T+3: `req_ready`=1.

**Load.** Accept at cycle T.
- T+1: ISSUE with `dm_ren`=1.
- T+2: WAIT; `dm_rdata` is valid, formatted and registered into `resp_rdata`.
- T+3: `resp_valid`.
- T+4: `req_ready`=1.

**Misaligned access.** Accept at T; `resp_valid=1` and `resp_exc=1` at T+1; IDLE at T+2.

**Throughput.** Back-to-back requests are possible only through IDLE, so there is at most one outstanding access.

**Reset.**
- At the reset edge: state becomes IDLE; all outputs become 0 except `req_ready`, which becomes 1 from the first cycle after reset.
- Reset during ISSUE, WAIT or RESP abandons the access. `dm_wen`, `dm_ren` and `resp_valid` are 0 from the reset edge, and no response is produced.

## Test plan
- **sw then lw.** sw addr 0x10, data 0xDEADBEEF → `dm_wen`=1 for one cycle, `dm_BE`=1111, `dm_addr`=0x10. Then lw 0x10 → `resp_rdata`=0xDEADBEEF with `resp_valid` 3 cycles after accept.
- **sb then lw.** sb addr 0x22, data 0x000000A5 → `dm_BE`=0100, `dm_wdata`=0xA5A5A5A5, `dm_addr`=0x20. A following lw 0x20 over a zeroed word → 0x00A50000.
- **Byte and half extension.** Memory word 0x80FF7F01. Expected results:
  - lb 0x3 → 0xFFFFFF80.
  - lbu 0x3 → 0x00000080.
  - lh 0x2 → 0xFFFF80FF.
  - lhu 0x0 → 0x00007F01.
- **Misaligned accesses.** lw 0x6 and sh 0x5 → each gives `resp_exc`=1 and `resp_rdata`=0 at accept+1; `dm_ren`/`dm_wen` are never asserted.
- **Reset mid-load.** Assert reset in the WAIT cycle → no `resp_valid`, all `dm_*` are 0, and `req_ready`=1 the cycle after reset deasserts.
- **Request gating.** Hold `req_valid` high for 8 cycles with alternating sw/lw → each request is accepted only when `req_ready`=1, and responses appear in order at the latencies above.
